// File: rtl/boreal_pkg.sv
// Shared definitions for the requant stage: scratchpad OUT region base,
// int8 saturation bounds and the FSM state encoding.
package boreal_pkg;

  localparam logic [10:0] SP_OUT_BASE = 11'h500;
  localparam int          INT8_MAX    = 127;
  localparam int          INT8_MIN    = -128;

  typedef enum logic [2:0] {
    RQ_IDLE,
    RQ_FETCH,
    RQ_DRAIN,
    RQ_QUANT,
    RQ_EMIT,
    RQ_DONE
  } rq_state_t;

endpackage

// File: rtl/boreal_requant.sv
// Combinational requantizer: multiply a group sum by a signed multiplier,
// round-shift right (round half toward +inf), add a zero point and saturate
// to int8.
// Ports:
//   acc    in   ACC_W   signed group sum
//   mult   in   MULT_W  signed multiplier
//   shift  in   5       right-shift amount 0..31
//   zp     in   8       signed zero point
//   q8     out  8       saturated int8 result
module boreal_requant
  import boreal_pkg::*;
#(
  parameter int ACC_W  = 40,
  parameter int MULT_W = 16
) (
  input  logic signed [ACC_W-1:0]  acc,
  input  logic signed [MULT_W-1:0] mult,
  input  logic        [4:0]        shift,
  input  logic signed [7:0]        zp,
  output logic signed [7:0]        q8
);

  localparam int P_W = ACC_W + MULT_W;
  // One extra bit so the rounding bias and zero point can never overflow.
  localparam int S_W = P_W + 1;

  localparam logic signed [S_W-1:0] SAT_HI = S_W'(INT8_MAX);
  localparam logic signed [S_W-1:0] SAT_LO = S_W'(INT8_MIN);

  logic signed [P_W-1:0] prod;
  logic signed [S_W-1:0] bias;
  logic signed [S_W-1:0] rounded;
  logic signed [S_W-1:0] shifted;
  logic signed [S_W-1:0] with_zp;

  assign prod    = P_W'(acc) * P_W'(mult);
  assign bias    = (shift == 5'd0) ? '0 : (S_W'(1) <<< (shift - 5'd1));
  assign rounded = S_W'(prod) + bias;
  assign shifted = rounded >>> shift;
  assign with_zp = shifted + S_W'(zp);

  always_comb begin
    q8 = with_zp[7:0];
    if (with_zp > SAT_HI) begin
      q8 = 8'(INT8_MAX);
    end else if (with_zp < SAT_LO) begin
      q8 = 8'(INT8_MIN);
    end
  end

endmodule

// File: rtl/boreal_vec_requant.sv
// Requant stage of the vector MAC engine. Reads signed 32-bit products from
// the scratchpad, sums each group of 1<<group_log2 products, requantizes the
// sum to int8 and emits one result per group on a valid/ready stream.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   start                       start pulse (sampled only when idle)
//   base_addr/len/group_log2    read window and grouping
//   q_mult/q_shift/q_zp         requant parameters
//   rd_en/rd_addr/rd_data       scratchpad read port (1-cycle latency)
//   out_valid/out_ready/out_data  int8 result stream
//   busy/done/err               status
module boreal_vec_requant
  import boreal_pkg::*;
#(
  parameter int SP_AW  = 11,
  parameter int ACC_W  = 40,
  parameter int MULT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [SP_AW-1:0]  base_addr,
  input  logic [15:0]       len,
  input  logic [2:0]        group_log2,
  input  logic [MULT_W-1:0] q_mult,
  input  logic [4:0]        q_shift,
  input  logic [7:0]        q_zp,
  output logic              rd_en,
  output logic [SP_AW-1:0]  rd_addr,
  input  logic [31:0]       rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_data,
  output logic              busy,
  output logic              done,
  output logic              err
);

  rq_state_t state_reg, state_next;

  logic [SP_AW-1:0]  addr_reg;
  logic [7:0]        cnt_reg;
  logic [7:0]        g_last_reg;
  logic [15:0]       groups_reg;
  logic [ACC_W-1:0]  acc_reg;
  logic [MULT_W-1:0] mult_reg;
  logic [4:0]        shift_reg;
  logic [7:0]        zp_reg;
  logic [7:0]        q_reg;
  logic              rd_valid_reg;
  logic              err_reg;

  logic [15:0] len_mask;
  logic        cfg_ok;
  logic        accept;
  logic [7:0]  q8;

  // len must be a non-zero whole number of groups.
  assign len_mask = (16'd1 << group_log2) - 16'd1;
  assign cfg_ok   = (len != 16'd0) && ((len & len_mask) == 16'd0);
  assign accept   = (state_reg == RQ_IDLE) && start && cfg_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= RQ_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    rd_en      = 1'b0;
    out_valid  = 1'b0;
    done       = 1'b0;
    busy       = (state_reg != RQ_IDLE);
    case (state_reg)
      RQ_IDLE:  if (accept) state_next = RQ_FETCH;
      RQ_FETCH: begin
        rd_en = 1'b1;
        if (cnt_reg == g_last_reg) state_next = RQ_DRAIN;
      end
      RQ_DRAIN: state_next = RQ_QUANT;
      RQ_QUANT: state_next = RQ_EMIT;
      RQ_EMIT: begin
        out_valid = 1'b1;
        if (out_ready) state_next = (groups_reg == 16'd1) ? RQ_DONE : RQ_FETCH;
      end
      RQ_DONE: begin
        done       = 1'b1;
        state_next = RQ_IDLE;
      end
      default:  state_next = RQ_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_reg     <= '0;
      cnt_reg      <= '0;
      g_last_reg   <= '0;
      groups_reg   <= '0;
      acc_reg      <= '0;
      mult_reg     <= '0;
      shift_reg    <= '0;
      zp_reg       <= '0;
      q_reg        <= '0;
      rd_valid_reg <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      err_reg      <= (state_reg == RQ_IDLE) && start && !cfg_ok;
      rd_valid_reg <= rd_en;

      // Read data lands one cycle after each strobe, including the cycle in DRAIN.
      if (rd_valid_reg) begin
        acc_reg <= acc_reg + ACC_W'($signed(rd_data));
      end

      case (state_reg)
        RQ_IDLE: begin
          if (accept) begin
            addr_reg   <= base_addr;
            cnt_reg    <= '0;
            g_last_reg <= (8'd1 << group_log2) - 8'd1;
            groups_reg <= len >> group_log2;
            acc_reg    <= '0;
            mult_reg   <= q_mult;
            shift_reg  <= q_shift;
            zp_reg     <= q_zp;
          end
        end
        RQ_FETCH: begin
          // Pointer carries over between groups; wraps naturally at SP_AW bits.
          addr_reg <= addr_reg + 1'b1;
          cnt_reg  <= cnt_reg + 8'd1;
        end
        RQ_QUANT: q_reg <= q8;
        RQ_EMIT: begin
          if (out_ready) begin
            groups_reg <= groups_reg - 16'd1;
            cnt_reg    <= '0;
            acc_reg    <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  boreal_requant #(
    .ACC_W (ACC_W),
    .MULT_W(MULT_W)
  ) u_requant (
    .acc  (acc_reg),
    .mult (mult_reg),
    .shift(shift_reg),
    .zp   (zp_reg),
    .q8   (q8)
  );

  assign rd_addr  = addr_reg;
  assign out_data = q_reg;
  assign err      = err_reg;

endmodule

// File: tb/tb_boreal_vec_requant.sv
// Directed testbench for boreal_vec_requant with a 1-cycle-latency
// scratchpad model and hand-computed expected results.
module tb_boreal_vec_requant;
  import boreal_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [10:0] base_addr;
  logic [15:0] len;
  logic [2:0]  group_log2;
  logic [15:0] q_mult;
  logic [4:0]  q_shift;
  logic [7:0]  q_zp;
  logic        rd_en;
  logic [10:0] rd_addr;
  logic [31:0] rd_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        busy;
  logic        done;
  logic        err;

  logic [31:0] mem [0:2047];

  int n_vec = 0;
  int n_bad = 0;

  int addr_q[$];
  int out_q[$];
  int first_valid;
  int done_at;
  int unstable;
  int rd_in_emit;

  always #5 clk = ~clk;

  boreal_vec_requant dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .len       (len),
    .group_log2(group_log2),
    .q_mult    (q_mult),
    .q_shift   (q_shift),
    .q_zp      (q_zp),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  // Scratchpad: data valid one cycle after the strobe, junk otherwise.
  always @(posedge clk) begin
    rd_data <= rd_en ? mem[rd_addr] : 32'h0BAD_0BAD;
  end

  task automatic check_vec(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  task automatic check_idle_zero(input string tag);
    check_vec({tag, " rd_en"},     int'(rd_en), 0);
    check_vec({tag, " rd_addr"},   int'(rd_addr), 0);
    check_vec({tag, " out_valid"}, int'(out_valid), 0);
    check_vec({tag, " out_data"},  int'(out_data), 0);
    check_vec({tag, " busy"},      int'(busy), 0);
    check_vec({tag, " done"},      int'(done), 0);
    check_vec({tag, " err"},       int'(err), 0);
  endtask

  // Starts one operation, scrambles config inputs afterwards, and records
  // read addresses and accepted outputs until done (bounded).
  task automatic run_op(input logic [10:0] b, input int n, input int gl, input int m,
                        input int sh, input int z, input int stall);
    int stall_left;
    int held;
    bit holding;
    addr_q.delete();
    out_q.delete();
    first_valid = -1;
    done_at     = -1;
    unstable    = 0;
    rd_in_emit  = 0;
    stall_left  = stall;
    held        = 0;
    holding     = 1'b0;
    base_addr  = b;
    len        = 16'(n);
    group_log2 = 3'(gl);
    q_mult     = 16'(m);
    q_shift    = 5'(sh);
    q_zp       = 8'(z);
    out_ready  = 1'b1;
    start      = 1'b1;
    @(posedge clk); #1;
    start      = 1'b0;
    base_addr  = 11'h3A5;
    len        = 16'h0003;
    group_log2 = 3'd7;
    q_mult     = 16'h7FFF;
    q_shift    = 5'd31;
    q_zp       = 8'h80;
    for (int i = 1; i <= 3000 && done_at < 0; i++) begin
      if (rd_en) addr_q.push_back(int'(rd_addr));
      if (out_valid) begin
        if (rd_en) rd_in_emit++;
        if (first_valid < 0) first_valid = i;
        if (holding && int'($signed(out_data)) != held) unstable++;
        if (stall_left > 0) begin
          out_ready = 1'b0;
          if (!holding) begin
            held    = int'($signed(out_data));
            holding = 1'b1;
          end
          stall_left--;
        end else begin
          out_ready = 1'b1;
          holding   = 1'b0;
          out_q.push_back(int'($signed(out_data)));
        end
      end else begin
        out_ready = 1'b1;
      end
      if (done) done_at = i;
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    if (done_at < 0) check_vec("timeout waiting for done", 0, 1);
  endtask

  task automatic reject(input string tag, input int n, input int gl);
    len        = 16'(n);
    group_log2 = 3'(gl);
    start      = 1'b1;
    @(posedge clk); #1;
    start      = 1'b0;
    check_vec({tag, " err"},   int'(err), 1);
    check_vec({tag, " rd_en"}, int'(rd_en), 0);
    check_vec({tag, " busy"},  int'(busy), 0);
    @(posedge clk); #1;
    check_vec({tag, " err gone"},   int'(err), 0);
    check_vec({tag, " rd_en later"}, int'(rd_en), 0);
  endtask

  task automatic load_t1();
    mem[11'h500] = 32'd100;
    mem[11'h501] = 32'd200;
    mem[11'h502] = -32'sd50;
    mem[11'h503] = 32'd10;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 32'd0;
    rst = 1'b1; start = 1'b0; base_addr = '0; len = '0; group_log2 = '0;
    q_mult = '0; q_shift = '0; q_zp = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_idle_zero("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // 1: sum 260, (260+2)>>2 = 65, +3 = 68
    load_t1();
    run_op(SP_OUT_BASE, 4, 2, 1, 2, 3, 0);
    check_vec("t1 count", out_q.size(), 1);
    check_vec("t1 data", out_q.size() > 0 ? out_q[0] : -999, 68);
    check_vec("t1 first valid cycle", first_valid, 7);
    check_vec("t1 done cycle", done_at, 8);
    check_vec("t1 busy after done", int'(busy), 0);
    check_vec("t1 reads", addr_q.size(), 4);
    check_vec("t1 addr0", addr_q.size() > 0 ? addr_q[0] : -1, 'h500);
    check_vec("t1 addr3", addr_q.size() > 3 ? addr_q[3] : -1, 'h503);

    // 2: saturation and negative rounding
    run_op(SP_OUT_BASE, 4, 2, 1, 0, 0, 0);
    check_vec("t2 sat high", out_q.size() > 0 ? out_q[0] : -999, 127);
    mem[11'h510] = -32'sd1000;
    run_op(11'h510, 4, 2, 1, 0, 0, 0);
    check_vec("t2 sat low", out_q.size() > 0 ? out_q[0] : -999, -128);
    mem[11'h520] = -32'sd10;
    run_op(11'h520, 4, 2, 1, 2, 0, 0);
    check_vec("t2 round -10>>2", out_q.size() > 0 ? out_q[0] : -999, -2);
    // G=1, 7*-3 = -21, (-21+1)>>>1 = -10, +5 = -5
    mem[11'h530] = 32'd7;
    run_op(11'h530, 1, 0, -3, 1, 5, 0);
    check_vec("t2 neg mult G1", out_q.size() > 0 ? out_q[0] : -999, -5);
    check_vec("t2 G1 first valid", first_valid, 4);
    // G=128 of ones: (128+1)>>>1 = 64, -100 = -36
    for (int k = 0; k < 128; k++) mem[11'h600 + k] = 32'd1;
    run_op(11'h600, 128, 7, 1, 1, -100, 0);
    check_vec("t2 G128 data", out_q.size() > 0 ? out_q[0] : -999, -36);
    check_vec("t2 G128 first valid", first_valid, 131);

    // 3: four groups of two
    for (int k = 0; k < 8; k++) mem[11'h500 + k] = 32'(k + 1);
    run_op(SP_OUT_BASE, 8, 1, 1, 0, 0, 0);
    check_vec("t3 count", out_q.size(), 4);
    for (int k = 0; k < 4; k++)
      check_vec($sformatf("t3 out%0d", k), out_q.size() > k ? out_q[k] : -999, 4 * k + 3);
    check_vec("t3 reads", addr_q.size(), 8);
    for (int k = 0; k < 8; k++)
      check_vec($sformatf("t3 addr%0d", k), addr_q.size() > k ? addr_q[k] : -1, 'h500 + k);
    check_vec("t3 done cycle", done_at, 21);

    // 4: backpressure for 5 cycles
    load_t1();
    run_op(SP_OUT_BASE, 4, 2, 1, 2, 3, 5);
    check_vec("t4 count", out_q.size(), 1);
    check_vec("t4 data", out_q.size() > 0 ? out_q[0] : -999, 68);
    check_vec("t4 data unstable", unstable, 0);
    check_vec("t4 rd_en in emit", rd_in_emit, 0);
    check_vec("t4 reads", addr_q.size(), 4);
    check_vec("t4 done cycle", done_at, 13);

    // 5: rejected starts
    reject("t5 len6 G4", 6, 2);
    reject("t5 len0", 0, 0);

    // 6: reset in the second FETCH cycle
    base_addr = SP_OUT_BASE; len = 16'd4; group_log2 = 3'd2;
    q_mult = 16'd1; q_shift = 5'd2; q_zp = 8'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check_idle_zero("t6 mid reset");
    rst = 1'b0;
    @(posedge clk); #1;
    run_op(SP_OUT_BASE, 4, 2, 1, 2, 3, 0);
    check_vec("t6 rerun data", out_q.size() > 0 ? out_q[0] : -999, 68);
    check_vec("t6 rerun done cycle", done_at, 8);

    // 7: address wrap
    mem[11'h7FE] = 32'd1;
    mem[11'h7FF] = 32'd2;
    mem[11'h000] = 32'd3;
    mem[11'h001] = 32'd4;
    run_op(11'h7FE, 4, 2, 1, 0, 0, 0);
    check_vec("t7 data", out_q.size() > 0 ? out_q[0] : -999, 10);
    check_vec("t7 addr0", addr_q.size() > 0 ? addr_q[0] : -1, 'h7FE);
    check_vec("t7 addr1", addr_q.size() > 1 ? addr_q[1] : -1, 'h7FF);
    check_vec("t7 addr2", addr_q.size() > 2 ? addr_q[2] : -1, 'h000);
    check_vec("t7 addr3", addr_q.size() > 3 ? addr_q[3] : -1, 'h001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
